// File: rtl/rx_pkg.sv
// ============================================================================
// Module  : rx_pkg
// Brief   : Shared status codes, preamble bytes and terminate-word helpers
//           for the receive frame path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_pkg;

    localparam logic [1:0] ST_DATA  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_TERM  = 2'b10;
    localparam logic [1:0] ST_OTHER = 2'b11;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] be;
        logic [3:0] cnt;
    } tail_t;

    // Data lanes of a terminate word are the clear bits of the control mask.
    function automatic tail_t tail_be(input logic [7:0] rxc);
        tail_t t;
        t.be  = '0;
        t.cnt = '0;
        for (int i = 0; i < 8; i++) begin
            if (!rxc[i]) t.cnt = t.cnt + 4'd1;
        end
        for (int i = 0; i < 8; i++) begin
            t.be[i] = (4'(i) < t.cnt);
        end
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_frame_assembler.sv
// ============================================================================
// Module  : rx_frame_assembler
// Brief   : Strips preamble/SFD and emits payload beats with SOF/EOF, byte
//           enables, length and error, using a one-word hold register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_assembler
    import rx_pkg::*;
#(
    parameter int MAX_BYTES = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pls_data,
    input  logic [1:0]  rx_data_st,
    input  logic [7:0]  rxc,
    output logic [63:0] frm_data,
    output logic        frm_valid,
    output logic        frm_sof,
    output logic        frm_eof,
    output logic [7:0]  frm_be,
    output logic        frm_err,
    output logic [15:0] frm_len,
    output logic [15:0] drop_cnt
);

    localparam logic [15:0] c_max_len = 16'(MAX_BYTES);

    state_t      r_state, w_state_nxt;
    logic [63:0] r_hold_data, w_hold_data_nxt;
    logic [7:0]  r_hold_be, w_hold_be_nxt;
    logic        r_hold_full, w_hold_full_nxt;
    logic        r_first, w_first_nxt;
    logic [15:0] r_len, w_len_nxt;

    logic        w_emit, w_emit_eof, w_emit_err;
    logic [1:0]  w_drop_inc;
    logic        w_check_start;
    logic        w_pre_ok;
    tail_t       w_tail;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_pre_ok = (pls_data[63:56] == SFD_BYTE) &&
                      (pls_data[55:0] == {7{PREAMBLE_BYTE}});
    assign w_tail   = tail_be(rxc);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_data_nxt = r_hold_data;
        w_hold_be_nxt   = r_hold_be;
        w_hold_full_nxt = r_hold_full;
        w_first_nxt     = r_first;
        w_len_nxt       = r_len;
        w_emit          = 1'b0;
        w_emit_eof      = 1'b0;
        w_emit_err      = 1'b0;
        w_drop_inc      = 2'd0;
        w_check_start   = 1'b0;

        case (r_state)
            S_IDLE: w_check_start = 1'b1;
            S_DATA: begin
                case (rx_data_st)
                    ST_DATA: begin
                        w_emit          = r_hold_full;
                        w_hold_data_nxt = pls_data;
                        w_hold_be_nxt   = 8'hFF;
                        w_hold_full_nxt = 1'b1;
                        w_len_nxt       = sat_add(r_len, 4'd8);
                    end
                    ST_TERM: begin
                        if (w_tail.cnt == 4'd0) begin
                            w_emit          = r_hold_full;
                            w_emit_eof      = 1'b1;
                            w_emit_err      = (r_len > c_max_len);
                            w_drop_inc      = r_hold_full ? 2'd0 : 2'd1;
                            w_hold_full_nxt = 1'b0;
                            w_state_nxt     = S_IDLE;
                        end else begin
                            // Partial tail becomes the EOF beat on the DRAIN cycle.
                            w_emit          = r_hold_full;
                            w_hold_data_nxt = pls_data;
                            w_hold_be_nxt   = w_tail.be;
                            w_hold_full_nxt = 1'b1;
                            w_len_nxt       = sat_add(r_len, w_tail.cnt);
                            w_state_nxt     = S_DRAIN;
                        end
                    end
                    default: begin
                        w_emit          = r_hold_full;
                        w_emit_eof      = 1'b1;
                        w_emit_err      = 1'b1;
                        w_drop_inc      = r_hold_full ? 2'd0 : 2'd1;
                        w_hold_full_nxt = 1'b0;
                        w_state_nxt     = S_IDLE;
                        w_check_start   = (rx_data_st == ST_START);
                    end
                endcase
            end
            S_DRAIN: begin
                w_emit          = 1'b1;
                w_emit_eof      = 1'b1;
                w_emit_err      = (r_len > c_max_len);
                w_hold_full_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
                w_check_start   = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_emit) w_first_nxt = 1'b0;

        // A start word may follow an abort or a DRAIN in the same cycle.
        if (w_check_start && (rx_data_st == ST_START)) begin
            if (w_pre_ok) begin
                w_state_nxt     = S_DATA;
                w_hold_full_nxt = 1'b0;
                w_len_nxt       = 16'd0;
                w_first_nxt     = 1'b1;
            end else begin
                w_drop_inc = w_drop_inc + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_data <= '0;
            r_hold_be   <= '0;
            r_hold_full <= 1'b0;
            r_first     <= 1'b0;
            r_len       <= '0;
            frm_data    <= '0;
            frm_valid   <= 1'b0;
            frm_sof     <= 1'b0;
            frm_eof     <= 1'b0;
            frm_be      <= '0;
            frm_err     <= 1'b0;
            frm_len     <= '0;
            drop_cnt    <= '0;
        end else begin
            r_hold_data <= w_hold_data_nxt;
            r_hold_be   <= w_hold_be_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_first     <= w_first_nxt;
            r_len       <= w_len_nxt;
            frm_valid   <= w_emit;
            frm_sof     <= w_emit & r_first;
            frm_eof     <= w_emit & w_emit_eof;
            if (w_emit) begin
                frm_data <= r_hold_data;
                frm_be   <= r_hold_be;
            end
            if (w_emit && w_emit_eof) begin
                frm_len <= r_len;
                frm_err <= w_emit_err;
            end
            drop_cnt <= sat_add(drop_cnt, {2'b00, w_drop_inc});
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_assembler.sv
// ============================================================================
// Module  : tb_rx_frame_assembler
// Brief   : Directed self-checking bench for rx_frame_assembler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_assembler;
    import rx_pkg::*;

    localparam logic [63:0] PRE  = 64'hD555_5555_5555_5555;
    localparam logic [63:0] BADP = 64'hD455_5555_5555_5555;
    localparam logic [63:0] WA   = 64'h0807_0605_0403_0201;
    localparam logic [63:0] WB   = 64'h1817_1615_1413_1211;
    localparam logic [63:0] WC   = 64'h2827_2625_2423_2221;
    localparam logic [63:0] WT   = 64'hFDFD_FDFD_FDFD_3231;
    localparam logic [63:0] IDL  = 64'h0707_0707_0707_0707;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pls_data = '0;
    logic [1:0]  rx_data_st = ST_OTHER;
    logic [7:0]  rxc = 8'hFF;

    logic [63:0] frm_data, f16_data;
    logic        frm_valid, frm_sof, frm_eof, frm_err;
    logic        f16_valid, f16_sof, f16_eof, f16_err;
    logic [7:0]  frm_be, f16_be;
    logic [15:0] frm_len, drop_cnt, f16_len, f16_drop;
    logic [10:0] flags;

    int total = 0;
    int bad   = 0;

    assign flags = {frm_valid, frm_sof, frm_eof, frm_be};

    always #5 clk = ~clk;

    rx_frame_assembler dut (
        .clk(clk), .rst(rst), .pls_data(pls_data), .rx_data_st(rx_data_st), .rxc(rxc),
        .frm_data(frm_data), .frm_valid(frm_valid), .frm_sof(frm_sof), .frm_eof(frm_eof),
        .frm_be(frm_be), .frm_err(frm_err), .frm_len(frm_len), .drop_cnt(drop_cnt)
    );

    rx_frame_assembler #(.MAX_BYTES(16)) dut16 (
        .clk(clk), .rst(rst), .pls_data(pls_data), .rx_data_st(rx_data_st), .rxc(rxc),
        .frm_data(f16_data), .frm_valid(f16_valid), .frm_sof(f16_sof), .frm_eof(f16_eof),
        .frm_be(f16_be), .frm_err(f16_err), .frm_len(f16_len), .drop_cnt(f16_drop)
    );

    task automatic cyc(input logic [1:0] st, input logic [63:0] d, input logic [7:0] c);
        rx_data_st = st;
        pls_data   = d;
        rxc        = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(ST_OTHER, IDL, 8'hFF);
        cyc(ST_OTHER, IDL, 8'hFF);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({flags, frm_err, frm_data, frm_len, drop_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs flags=%b err=%b data=%h len=%0d drop=%0d want all zero",
                     flags, frm_err, frm_data, frm_len, drop_cnt);
        end
    endtask

    task automatic test_basic_frame();
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        total++;
        if (frm_valid !== 1'b0) begin
            bad++; $display("FAIL basic_no_early_beat valid=%b want 0", frm_valid);
        end
        cyc(ST_DATA, WB, 8'h00);
        total++;
        if (flags !== {3'b110, 8'hFF} || frm_data !== WA) begin
            bad++; $display("FAIL basic_beatA flags=%b data=%h want %b %h", flags, frm_data, {3'b110, 8'hFF}, WA);
        end
        cyc(ST_TERM, WT, 8'hFC);
        total++;
        if (flags !== {3'b100, 8'hFF} || frm_data !== WB) begin
            bad++; $display("FAIL basic_beatB flags=%b data=%h want %b %h", flags, frm_data, {3'b100, 8'hFF}, WB);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
        total++;
        if (flags !== {3'b101, 8'h03} || frm_data !== WT || frm_len !== 16'd18 || frm_err !== 1'b0) begin
            bad++; $display("FAIL basic_tail flags=%b data=%h len=%0d err=%b want %b %h 18 0",
                            flags, frm_data, frm_len, frm_err, {3'b101, 8'h03}, WT);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
        total++;
        if (frm_valid !== 1'b0) begin
            bad++; $display("FAIL basic_idle_after valid=%b want 0", frm_valid);
        end
    endtask

    task automatic test_single_beat();
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        cyc(ST_TERM, IDL, 8'hFF);
        total++;
        if (flags !== {3'b111, 8'hFF} || frm_data !== WA || frm_len !== 16'd8 || frm_err !== 1'b0) begin
            bad++; $display("FAIL single_beat flags=%b data=%h len=%0d err=%b want %b %h 8 0",
                            flags, frm_data, frm_len, frm_err, {3'b111, 8'hFF}, WA);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
    endtask

    task automatic test_drops();
        do_reset();
        cyc(ST_START, BADP, 8'hFF);
        total++;
        if (frm_valid !== 1'b0 || drop_cnt !== 16'd1) begin
            bad++; $display("FAIL drop_bad_sfd valid=%b drop=%0d want 0 1", frm_valid, drop_cnt);
        end
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_TERM, IDL, 8'hFF);
        total++;
        if (frm_valid !== 1'b0 || drop_cnt !== 16'd2) begin
            bad++; $display("FAIL drop_empty_term valid=%b drop=%0d want 0 2", frm_valid, drop_cnt);
        end
        // Terminate with no full data word but a few bytes: SOF+EOF via DRAIN.
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_TERM, WT, 8'hF0);
        total++;
        if (frm_valid !== 1'b0) begin
            bad++; $display("FAIL short_term_edge valid=%b want 0", frm_valid);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
        total++;
        if (flags !== {3'b111, 8'h0F} || frm_data !== WT || frm_len !== 16'd4 || drop_cnt !== 16'd2) begin
            bad++; $display("FAIL short_frame flags=%b data=%h len=%0d drop=%0d want %b %h 4 2",
                            flags, frm_data, frm_len, drop_cnt, {3'b111, 8'h0F}, WT);
        end
    endtask

    task automatic test_abort();
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        cyc(ST_OTHER, IDL, 8'hFF);
        total++;
        if (flags !== {3'b111, 8'hFF} || frm_data !== WA || frm_err !== 1'b1 || frm_len !== 16'd8) begin
            bad++; $display("FAIL abort_beat flags=%b data=%h err=%b len=%0d want %b %h 1 8",
                            flags, frm_data, frm_err, frm_len, {3'b111, 8'hFF}, WA);
        end
        cyc(ST_DATA, WB, 8'h00);
        cyc(ST_DATA, WC, 8'h00);
        cyc(ST_TERM, IDL, 8'hFF);
        total++;
        if (frm_valid !== 1'b0 || drop_cnt !== 16'd2) begin
            bad++; $display("FAIL abort_ignores_data valid=%b drop=%0d want 0 2", frm_valid, drop_cnt);
        end
        // A new start in the middle of a frame aborts it and opens the next one.
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        cyc(ST_START, PRE, 8'hFF);
        total++;
        if (flags !== {3'b111, 8'hFF} || frm_err !== 1'b1) begin
            bad++; $display("FAIL restart_abort flags=%b err=%b want %b 1", flags, frm_err, {3'b111, 8'hFF});
        end
        cyc(ST_DATA, WB, 8'h00);
        cyc(ST_TERM, IDL, 8'hFF);
        total++;
        if (flags !== {3'b111, 8'hFF} || frm_data !== WB || frm_err !== 1'b0 || frm_len !== 16'd8) begin
            bad++; $display("FAIL restart_frame flags=%b data=%h err=%b len=%0d want %b %h 0 8",
                            flags, frm_data, frm_err, frm_len, {3'b111, 8'hFF}, WB);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
    endtask

    task automatic test_back_to_back();
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        cyc(ST_TERM, WT, 8'hF8);
        total++;
        if (flags !== {3'b110, 8'hFF} || frm_data !== WA) begin
            bad++; $display("FAIL b2b_beatA flags=%b data=%h want %b %h", flags, frm_data, {3'b110, 8'hFF}, WA);
        end
        cyc(ST_START, PRE, 8'hFF);
        total++;
        if (flags !== {3'b101, 8'h07} || frm_data !== WT || frm_len !== 16'd11 || frm_err !== 1'b0) begin
            bad++; $display("FAIL b2b_tail flags=%b data=%h len=%0d err=%b want %b %h 11 0",
                            flags, frm_data, frm_len, frm_err, {3'b101, 8'h07}, WT);
        end
        cyc(ST_DATA, WC, 8'h00);
        total++;
        if (frm_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_gap valid=%b want 0", frm_valid);
        end
        cyc(ST_TERM, IDL, 8'hFF);
        total++;
        if (flags !== {3'b111, 8'hFF} || frm_data !== WC || frm_len !== 16'd8) begin
            bad++; $display("FAIL b2b_second flags=%b data=%h len=%0d want %b %h 8",
                            flags, frm_data, frm_len, {3'b111, 8'hFF}, WC);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
    endtask

    task automatic test_oversize();
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        cyc(ST_DATA, WB, 8'h00);
        cyc(ST_DATA, WC, 8'h00);
        cyc(ST_TERM, IDL, 8'hFF);
        total++;
        if (f16_valid !== 1'b1 || f16_eof !== 1'b1 || f16_err !== 1'b1 || f16_len !== 16'd24 || f16_data !== WC) begin
            bad++; $display("FAIL oversize_max16 valid=%b eof=%b err=%b len=%0d data=%h want 1 1 1 24 %h",
                            f16_valid, f16_eof, f16_err, f16_len, f16_data, WC);
        end
        total++;
        if (frm_eof !== 1'b1 || frm_err !== 1'b0 || frm_len !== 16'd24) begin
            bad++; $display("FAIL oversize_default eof=%b err=%b len=%0d want 1 0 24", frm_eof, frm_err, frm_len);
        end
        cyc(ST_OTHER, IDL, 8'hFF);
    endtask

    task automatic test_reset_midframe();
        cyc(ST_START, BADP, 8'hFF);
        cyc(ST_START, PRE, 8'hFF);
        cyc(ST_DATA, WA, 8'h00);
        cyc(ST_DATA, WB, 8'h00);
        total++;
        if (frm_valid !== 1'b1 || drop_cnt === 16'd0) begin
            bad++; $display("FAIL midrst_setup valid=%b drop=%0d want 1 nonzero", frm_valid, drop_cnt);
        end
        rst = 1'b1;
        cyc(ST_DATA, WC, 8'h00);
        total++;
        if ({flags, frm_err, frm_data, frm_len, drop_cnt} !== '0) begin
            bad++; $display("FAIL midrst_clear flags=%b err=%b data=%h len=%0d drop=%0d want all zero",
                            flags, frm_err, frm_data, frm_len, drop_cnt);
        end
        rst = 1'b0;
        cyc(ST_TERM, IDL, 8'hFF);
        cyc(ST_OTHER, IDL, 8'hFF);
        total++;
        if (frm_valid !== 1'b0 || frm_eof !== 1'b0 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL midrst_no_eof valid=%b eof=%b drop=%0d want 0 0 0", frm_valid, frm_eof, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_beat();
        test_drops();
        test_abort();
        test_back_to_back();
        test_oversize();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_frame_assembler.md
# rx_frame_assembler

Receive-path stage directly downstream of the XGMII control-character decoder. Consumes the decoder's 64-bit lane-ordered word stream and 2-bit word status, validates the preamble/SFD word, and strips it. Emits the frame payload as 64-bit beats with start/end markers, byte enables, frame length and error flags to the MAC receive logic. Runs at line rate with no backpressure; a one-word hold register lets end-of-frame be flagged on the correct beat.

## Interface
- MAX_BYTES, 1518: frame length above which FRM_ERR is raised at end of frame.
- CLK  in  1  sole clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- PLS_DATA  in  64  decoder data; lane 0 = bits 7:0 = first byte on the wire.
- RX_DATA_ST  in  2  decoder status: 00 data, 01 start, 10 terminate, 11 other/error.
- RXC  in  8  raw control mask aligned with PLS_DATA; used only on terminate words.
- FRM_DATA  out  64  payload beat.
- FRM_VALID  out  1  beat valid, one-cycle qualifier.
- FRM_SOF  out  1  first beat of frame.
- FRM_EOF  out  1  last beat of frame.
- FRM_BE  out  8  byte enables for the beat; contiguous from lane 0.
- FRM_ERR  out  1  valid only with FRM_EOF; frame aborted or oversize.
- FRM_LEN  out  16  total payload bytes; valid with FRM_EOF; saturates at 16'hFFFF.
- DROP_CNT  out  16  frames discarded before any beat was emitted; saturating.

## Operation
- States: IDLE, DATA, DRAIN.
- IDLE: status 01 with PLS_DATA[63:56]==8'hD5 and lanes 0..6 == 8'h55 -> DATA, hold empty, length 0. Status 01 with a bad preamble/SFD -> DROP_CNT+1, stay IDLE. All other statuses are ignored.
- DATA, status 00:
  - if hold full, emit hold (BE=FF; SOF if it is the first beat);
  - load the word into hold; length += 8.
- DATA, status 10: n = 8 - popcount(RXC), which gives 0..7 valid bytes.
  - n=0: emit hold with EOF; go to IDLE.
  - n>0: emit hold without EOF; load the partial word into hold with BE = (1<<n)-1 and EOF pending; length += n; go to DRAIN.
  - Hold empty (no data word received): n=0 -> DROP_CNT+1, no output. n>0 -> single beat is SOF+EOF, emitted via DRAIN.
- DATA, status 11: abort. Emit hold with EOF+ERR (DROP_CNT+1 if hold empty); go to IDLE.
- DATA, status 01: abort the current frame exactly as for 11 in the same cycle, then run the IDLE start check on this word.
- DRAIN: emit hold (EOF, ERR if length>MAX_BYTES); go to IDLE. The input word this cycle is evaluated with IDLE rules, so back-to-back start is accepted.
- FRM_ERR is also set on a normal EOF when final length > MAX_BYTES.
- Length counter saturates at 16'hFFFF and never wraps.
- FRM_DATA bytes beyond FRM_BE are don't-care but pass through unmodified.

## Timing
- All outputs registered. Reset values: FRM_DATA 0, FRM_VALID/SOF/EOF/ERR 0, FRM_BE 0, FRM_LEN 0, DROP_CNT 0, state IDLE, hold empty.
- A data word accepted at edge t appears on FRM_* at the edge that accepts the next status word after it (00/10/11/01). Minimum latency is 1 cycle.
- Partial terminate beat appears exactly 1 cycle after the terminate edge (DRAIN).
- FRM_VALID is never high two cycles without a corresponding input word, apart from the single DRAIN cycle.
- FRM_LEN and FRM_ERR are meaningful only when FRM_VALID&FRM_EOF; they are held at other times.
- RST asserted mid-frame: the next edge clears the frame silently. No EOF is emitted and DROP_CNT is cleared.

## Structure
- Shared package rx_pkg holds:
  - status codes ST_DATA=2'b00, ST_START=2'b01, ST_TERM=2'b10, ST_OTHER=2'b11;
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - function tail_be(rxc) returning the byte-enable mask and byte count for a terminate word.
- No sub-module. Hold register, FSM and counters live in one module.

## Test plan
- Start (55..55 D5), data words A,B, terminate RXC=8'hFC -> beats A (SOF, BE FF), B (BE FF), tail (EOF, BE 03), FRM_LEN=18, ERR 0.
- Start, data A, terminate RXC=8'hFF -> single beat A with SOF+EOF, BE FF, FRM_LEN=8.
- Start with lane7=8'hD4 -> no beats, DROP_CNT=1; start, terminate RXC=FF -> DROP_CNT=2.
- Start, data A, status 11 -> A with SOF+EOF+ERR; following data words ignored until the next valid start.
- Terminate RXC=F8 with DRAIN coinciding with a new valid start, then data C, terminate FF -> prior tail EOF BE 07, then C SOF+EOF; no beat lost.
- MAX_BYTES=16: start, 3 data words, terminate FF -> EOF with ERR=1, FRM_LEN=24. Separately, RST mid-frame -> no EOF, all outputs 0 next cycle.
